// File: rtl/uart_tx_if.sv
// Host register-port bundle for the UART transmitter: write strobe, address,
// data, and the holding-register-empty flag returned to the host.
interface uart_tx_if;
  logic        wr_en;
  logic [11:0] waddr;
  logic [7:0]  wdata;
  logic        tx_ready;

  // Host side drives the write port and observes tx_ready.
  modport master (
    output wr_en,
    output waddr,
    output wdata,
    input  tx_ready
  );

  // Transmitter side consumes writes and reports holding-register state.
  modport slave (
    input  wr_en,
    input  waddr,
    input  wdata,
    output tx_ready
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register fed by the host register port,
// serialised as start / data (LSB first) / optional parity / 1-2 stop bits.
// Bit timing comes from an external 16x-oversample tick.
// Frames are only launched while the remote end holds cts_n low,
// and run back-to-back when the next byte is already waiting.
module uart_tx #(
  parameter logic [11:0] TX_ADDR = 12'h000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  uart_tx_if.slave   host,
  input  logic [1:0] data_bit_num,
  input  logic       stop_bit_num,
  input  logic       parity_en,
  input  logic       parity_type,
  input  logic       cts_n,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t      state_q,     state_d;
  logic [7:0]  hold_q,      hold_d;
  logic        hold_full_q, hold_full_d;
  logic [7:0]  shift_q,     shift_d;
  logic [3:0]  tick_cnt_q,  tick_cnt_d;
  logic [2:0]  bit_cnt_q,   bit_cnt_d;
  logic        parity_q,    parity_d;
  logic [1:0]  dbn_q,       dbn_d;
  logic        sbn_q,       sbn_d;
  logic        pen_q,       pen_d;
  logic        ptype_q,     ptype_d;
  logic        tx_q,        tx_d;
  logic        tx_done_q,   tx_done_d;

  logic        bit_end;
  logic        load_ok;
  logic        load;
  logic        wr_hit;
  logic        par_next;

  // Next-state logic: bit sequencing, frame launch and holding-register update.
  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    shift_d     = shift_q;
    tick_cnt_d  = tick_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    parity_d    = parity_q;
    dbn_d       = dbn_q;
    sbn_d       = sbn_q;
    pen_d       = pen_q;
    ptype_d     = ptype_q;
    tx_d        = tx_q;
    tx_done_d   = 1'b0;
    load        = 1'b0;
    par_next    = parity_q ^ shift_q[0];

    bit_end = tick && (tick_cnt_q == 4'd15);
    // cts_n only matters at the instant a new frame would be launched.
    load_ok = tick && hold_full_q && !cts_n;
    wr_hit  = host.wr_en && (host.waddr == TX_ADDR);

    if ((state_q != IDLE) && tick) begin
      tick_cnt_d = tick_cnt_q + 4'd1;
    end

    case (state_q)
      IDLE: begin
        if (load_ok) begin
          load = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          parity_d  = par_next;
          shift_d   = {1'b0, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          // Last data bit index is 4..7 for 5..8 data bits.
          if (bit_cnt_q == {1'b1, dbn_q}) begin
            bit_cnt_d = 3'd0;
            if (pen_q) begin
              state_d = PARITY;
              tx_d    = par_next ^ ptype_q;
            end else begin
              state_d = STOP;
              tx_d    = 1'b1;
            end
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          state_d   = STOP;
          tx_d      = 1'b1;
          bit_cnt_d = 3'd0;
        end
      end
      STOP: begin
        if (bit_end) begin
          // bit_cnt counts completed stop bits; second one only when configured.
          if (bit_cnt_q[0] == sbn_q) begin
            tx_done_d = 1'b1;
            if (load_ok) begin
              load = 1'b1;
            end else begin
              state_d = IDLE;
              tx_d    = 1'b1;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase

    // Frame launch: snapshot the byte and the format so mid-frame config
    // changes cannot disturb the frame on the wire.
    if (load) begin
      shift_d     = hold_q;
      hold_full_d = 1'b0;
      dbn_d       = data_bit_num;
      sbn_d       = stop_bit_num;
      pen_d       = parity_en;
      ptype_d     = parity_type;
      parity_d    = 1'b0;
      tick_cnt_d  = 4'd0;
      bit_cnt_d   = 3'd0;
      state_d     = START;
      tx_d        = 1'b0;
    end

    // A write landing on the load edge refills the register just emptied.
    if (wr_hit && (!hold_full_q || load)) begin
      hold_d      = host.wdata;
      hold_full_d = 1'b1;
    end
  end

  // State registers; reset forces the line idle and discards held data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      hold_q      <= 8'h00;
      hold_full_q <= 1'b0;
      shift_q     <= 8'h00;
      tick_cnt_q  <= 4'd0;
      bit_cnt_q   <= 3'd0;
      parity_q    <= 1'b0;
      dbn_q       <= 2'b11;
      sbn_q       <= 1'b0;
      pen_q       <= 1'b0;
      ptype_q     <= 1'b0;
      tx_q        <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      shift_q     <= shift_d;
      tick_cnt_q  <= tick_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      dbn_q       <= dbn_d;
      sbn_q       <= sbn_d;
      pen_q       <= pen_d;
      ptype_q     <= ptype_d;
      tx_q        <= tx_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx            = tx_q;
  assign tx_done       = tx_done_q;
  assign tx_busy       = (state_q != IDLE);
  assign host.tx_ready = !hold_full_q;

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: table of frame formats with hand-derived line
// sequences, a line monitor scoreboard, and directed flow-control,
// back-to-back and reset sequences.
module tb_uart_tx;

  localparam logic [11:0] ADDR = 12'h004;

  logic       clk;
  logic       rst_n;
  logic       tick;
  logic [1:0] data_bit_num;
  logic       stop_bit_num;
  logic       parity_en;
  logic       parity_type;
  logic       cts_n;
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  uart_tx_if bus ();

  uart_tx #(.TX_ADDR(ADDR)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tick         (tick),
    .host         (bus),
    .data_bit_num (data_bit_num),
    .stop_bit_num (stop_bit_num),
    .parity_en    (parity_en),
    .parity_type  (parity_type),
    .cts_n        (cts_n),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done      (tx_done)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int frame_no = 0;

  string exp_q[$];
  int    start_cycs[$];
  int    done_cycs[$];

  typedef struct {
    logic [7:0] data;
    logic [1:0] dbn;
    logic       sbn;
    logic       pen;
    logic       ptype;
    string      frame;   // expected line levels, one char per bit, in send order
  } vec_t;

  vec_t vecs[7];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) if (tx_done === 1'b1) done_cnt <= done_cnt + 1;

  // Tick every 4th clock.
  initial begin
    int tcnt;
    tcnt = 0;
    tick = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      tick = (tcnt == 3);
      tcnt = (tcnt + 1) % 4;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s value=%0h", name, act);
    end
  endtask

  // Line monitor: every start bit pops an expected frame and each bit must
  // hold its level for exactly 16 ticks, then tx_done must follow.
  initial begin
    string fr;
    int    total;
    int    n;
    int    mism;
    int    fidx;
    bit    skip;
    logic  expb;
    skip = 1'b0;
    forever begin
      if (!skip) @(negedge clk);
      skip = 1'b0;
      if (rst_n === 1'b1 && tx === 1'b0) begin
        start_cycs.push_back(cyc);
        chk("frame_expected", exp_q.size() > 0, 1);
        if (exp_q.size() == 0) begin
          while (tx !== 1'b1) @(negedge clk);
        end else begin
          fr    = exp_q.pop_front();
          fidx  = frame_no;
          frame_no++;
          total = fr.len() * 16;
          n     = 0;
          mism  = 0;
          while (n < total && rst_n === 1'b1) begin
            if (tick === 1'b1) begin
              expb = (fr[n / 16] == "1");
              if (tx !== expb) mism++;
              n++;
              if (n % 16 == 0) begin
                chk($sformatf("frame%0d_bit%0d_bad_samples", fidx, n / 16 - 1), mism, 0);
                mism = 0;
              end
            end
            if (n < total) @(negedge clk);
          end
          if (rst_n === 1'b1) begin
            @(negedge clk);
            chk($sformatf("frame%0d_tx_done", fidx), tx_done, 1);
            done_cycs.push_back(cyc);
            skip = 1'b1;
          end
        end
      end
    end
  end

  task automatic wr(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.waddr = a;
    bus.wdata = d;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_start(input int budget);
    int k;
    k = 0;
    while (tx !== 1'b0 && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("start_in_time", tx === 1'b0, 1);
  endtask

  task automatic wait_done(input int target, input int budget);
    int k;
    k = 0;
    while (done_cnt < target && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk("done_in_time", done_cnt >= target, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_cfg(input logic [1:0] dbn, input logic sbn, input logic pen, input logic pt);
    data_bit_num = dbn;
    stop_bit_num = sbn;
    parity_en    = pen;
    parity_type  = pt;
  endtask

  initial begin
    int sidx;
    int didx;
    int n;

    vecs[0] = '{8'hA5, 2'b11, 1'b0, 1'b0, 1'b0, "0101001011"};   // 8N1
    vecs[1] = '{8'h53, 2'b10, 1'b1, 1'b1, 1'b0, "01100101011"};  // 7E2
    vecs[2] = '{8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, "01111101"};     // 5O1
    vecs[3] = '{8'h2A, 2'b01, 1'b1, 1'b0, 1'b0, "001010111"};    // 6N2
    vecs[4] = '{8'h00, 2'b11, 1'b0, 1'b1, 1'b1, "00000000011"};  // 8O1
    vecs[5] = '{8'h16, 2'b00, 1'b0, 1'b1, 1'b0, "00110111"};     // 5E1
    vecs[6] = '{8'h80, 2'b10, 1'b0, 1'b0, 1'b0, "000000001"};    // 7N1

    bus.wr_en = 1'b0;
    bus.waddr = 12'h000;
    bus.wdata = 8'h00;
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    cts_n = 1'b0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("reset_tx", tx, 1);
    chk("reset_tx_ready", bus.tx_ready, 1);
    chk("reset_tx_busy", tx_busy, 0);
    chk("reset_tx_done", tx_done, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Wrong address is ignored.
    wr(ADDR + 12'h001, 8'h77);
    repeat (20) @(negedge clk);
    chk("wrong_addr_ready", bus.tx_ready, 1);
    chk("wrong_addr_tx", tx, 1);

    // Table-driven frame formats; config is scrambled mid-frame.
    for (int i = 0; i < 7; i++) begin
      set_cfg(vecs[i].dbn, vecs[i].sbn, vecs[i].pen, vecs[i].ptype);
      wr(ADDR, vecs[i].data);
      exp_q.push_back(vecs[i].frame);
      chk($sformatf("vec%0d_ready_low", i), bus.tx_ready, 0);
      wait_start(40);
      chk($sformatf("vec%0d_ready_after_load", i), bus.tx_ready, 1);
      chk($sformatf("vec%0d_busy", i), tx_busy, 1);
      repeat (30) @(negedge clk);
      set_cfg(2'($urandom_range(3)), 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)));
      cts_n = 1'($urandom_range(1));
      exp_done++;
      wait_done(exp_done, 1000);
      cts_n = 1'b0;
      chk($sformatf("vec%0d_idle_busy", i), tx_busy, 0);
      chk($sformatf("vec%0d_idle_tx", i), tx, 1);
    end

    // Flow control: held off by cts_n, launched on the next tick after release.
    set_cfg(2'b11, 1'b0, 1'b0, 1'b0);
    cts_n = 1'b1;
    wr(ADDR, 8'h3C);
    exp_q.push_back("0001111001");
    repeat (200) @(negedge clk);
    chk("cts_hold_tx", tx, 1);
    chk("cts_hold_ready", bus.tx_ready, 0);
    chk("cts_hold_busy", tx_busy, 0);
    do @(negedge clk); while (tick !== 1'b1);
    cts_n = 1'b0;
    @(negedge clk);
    chk("cts_release_start", tx, 0);
    chk("cts_release_busy", tx_busy, 1);
    n = 0;
    while (n < 40) begin
      @(negedge clk);
      if (tick === 1'b1) n++;
    end
    cts_n = 1'b1;
    exp_done++;
    wait_done(exp_done, 1000);
    cts_n = 1'b0;
    chk("cts_frame_idle_tx", tx, 1);

    // Back-to-back: second write on the load edge, third write dropped.
    sidx = start_cycs.size();
    didx = done_cycs.size();
    do @(negedge clk); while (tick !== 1'b1);
    @(negedge clk);
    bus.wr_en = 1'b1;
    bus.waddr = ADDR;
    bus.wdata = 8'h81;
    @(negedge clk);
    bus.wr_en = 1'b0;
    exp_q.push_back("0100000011");
    do @(negedge clk); while (tick !== 1'b1);
    bus.wr_en = 1'b1;
    bus.wdata = 8'h7E;
    @(negedge clk);
    bus.wr_en = 1'b0;
    exp_q.push_back("0011111101");
    chk("b2b_first_start", tx, 0);
    chk("b2b_ready_low", bus.tx_ready, 0);
    wr(ADDR, 8'hEE);
    chk("b2b_third_ready_low", bus.tx_ready, 0);
    exp_done += 2;
    wait_done(exp_done, 2000);
    if (start_cycs.size() >= sidx + 2 && done_cycs.size() >= didx + 1)
      chk("b2b_idle_gap", start_cycs[sidx + 1] - done_cycs[didx], 0);
    else
      chk("b2b_frame_count", start_cycs.size() - sidx, 2);
    repeat (300) @(negedge clk);
    chk("b2b_third_dropped", done_cnt, exp_done);
    chk("b2b_end_tx", tx, 1);
    chk("b2b_end_ready", bus.tx_ready, 1);

    // Reset in data bit 3 with a byte waiting in the holding register.
    wr(ADDR, 8'hC3);
    exp_q.push_back("0110000111");
    wait_start(40);
    wr(ADDR, 8'h99);
    n = 0;
    while (n < 72) begin
      @(negedge clk);
      if (tick === 1'b1) n++;
    end
    chk("pre_reset_bit3", tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_tx", tx, 1);
    chk("async_reset_ready", bus.tx_ready, 1);
    chk("async_reset_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("post_reset_no_frame", tx, 1);
    chk("post_reset_no_done", done_cnt, exp_done);
    wr(ADDR, 8'h5A);
    exp_q.push_back("0010110101");
    exp_done++;
    wait_done(exp_done, 1000);
    chk("post_reset_idle_busy", tx_busy, 0);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
